// File: rtl/anc_lms_coef_update.sv
// LMS coefficient writer for the ANC coefficient memory.
// Each Start latches an error sample, pushes a reference sample into the tap
// delay line and runs one pass over the memory: every coefficient read on
// WzOut is updated to sat(w + (e*x[k] >>> MU_SHIFT)) and returned on WzIn.
module anc_lms_coef_update #(
   parameter int TAPS       = 32,
   parameter int W          = 11,
   parameter int MU_SHIFT   = 8,
   parameter int FC_TIMEOUT = 15
) (
   input  logic                Clk_100M,
   input  logic                Reset,
   input  logic                Start,
   input  logic signed [W-1:0] ErrIn,
   input  logic signed [W-1:0] RefIn,
   input  logic signed [W-1:0] WzOut,
   input  logic                FiltComplete,
   output logic                FilterEN,
   output logic signed [W-1:0] WzIn,
   output logic                UpdValid,
   output logic                Busy,
   output logic                Done,
   output logic                Overflow,
   output logic                ProtoErr
);

   localparam int KW = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam int TW = $clog2(FC_TIMEOUT + 1);

   // Saturation bounds expressed at the full sum width (2W+1 bits).
   localparam logic signed [2*W:0] SMAX = {{(W+2){1'b0}}, {(W-1){1'b1}}};
   localparam logic signed [2*W:0] SMIN = {{(W+2){1'b1}}, {(W-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      STREAM,
      WAIT_FC,
      DONE
   } state_t;

   state_t              state;
   logic signed [W-1:0] x_line [TAPS];
   logic signed [W-1:0] e_lat;
   logic [KW-1:0]       tap_p0;
   logic                vld_p0;
   logic [TW-1:0]       wait_cnt;

   logic signed [W-1:0]   x_sel_p0;
   logic signed [2*W-1:0] prod_p0;
   logic signed [2*W-1:0] step_p0;
   logic signed [2*W:0]   sum_p0;

   // Clamp a full-width sum into the coefficient range.
   function automatic logic signed [W-1:0] sat_coef(input logic signed [2*W:0] s);
      if (s > SMAX) begin
         return SMAX[W-1:0];
      end else if (s < SMIN) begin
         return SMIN[W-1:0];
      end
      return s[W-1:0];
   endfunction

   // True when the sum lies outside the coefficient range.
   function automatic logic sat_hit(input logic signed [2*W:0] s);
      return (s > SMAX) || (s < SMIN);
   endfunction

   // ---- stage p0: tap sample on WzOut, product, step, sum ----
   assign x_sel_p0 = x_line[tap_p0];
   assign prod_p0  = (2*W)'(e_lat) * (2*W)'(x_sel_p0);
   assign step_p0  = prod_p0 >>> MU_SHIFT;
   assign sum_p0   = (2*W+1)'(WzOut) + (2*W+1)'(step_p0);

   assign Busy = (state != IDLE);

   // Pass sequencer, delay line, error latch and registered outputs (stage p1).
   always_ff @(posedge Clk_100M or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         FilterEN <= 1'b0;
         WzIn     <= '0;
         UpdValid <= 1'b0;
         Done     <= 1'b0;
         Overflow <= 1'b0;
         ProtoErr <= 1'b0;
         e_lat    <= '0;
         tap_p0   <= '0;
         vld_p0   <= 1'b0;
         wait_cnt <= '0;
         for (int k = 0; k < TAPS; k++) begin
            x_line[k] <= '0;
         end
      end else begin
         Done     <= 1'b0;
         UpdValid <= 1'b0;
         // A memory end-of-pass outside WAIT_FC is a protocol violation.
         if (FiltComplete && (state != WAIT_FC)) begin
            ProtoErr <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (Start) begin
                  for (int k = TAPS - 1; k > 0; k--) begin
                     x_line[k] <= x_line[k-1];
                  end
                  x_line[0] <= RefIn;
                  e_lat     <= ErrIn;
                  tap_p0    <= '0;
                  vld_p0    <= 1'b0;
                  FilterEN  <= 1'b1;
                  state     <= STREAM;
               end
            end
            STREAM: begin
               if (FiltComplete) begin
                  // Abort: nothing further is written, earlier taps stay.
                  FilterEN <= 1'b0;
                  vld_p0   <= 1'b0;
                  state    <= IDLE;
               end else if (!vld_p0) begin
                  // First enabled cycle is the memory read latency.
                  vld_p0 <= 1'b1;
               end else begin
                  // ---- stage p1: saturated coefficient back to memory ----
                  WzIn     <= sat_coef(sum_p0);
                  UpdValid <= 1'b1;
                  if (sat_hit(sum_p0)) begin
                     Overflow <= 1'b1;
                  end
                  if (tap_p0 == KW'(TAPS - 1)) begin
                     vld_p0   <= 1'b0;
                     FilterEN <= 1'b0;
                     wait_cnt <= '0;
                     state    <= WAIT_FC;
                  end else begin
                     tap_p0 <= tap_p0 + KW'(1);
                  end
               end
            end
            WAIT_FC: begin
               if (FiltComplete) begin
                  Done  <= 1'b1;
                  state <= DONE;
               end else if (wait_cnt == TW'(FC_TIMEOUT - 1)) begin
                  ProtoErr <= 1'b1;
                  state    <= IDLE;
               end else begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_anc_lms_coef_update.sv
// Bench for anc_lms_coef_update: directed passes plus randomized passes,
// checked against a plain-arithmetic LMS reference model.
module tb_anc_lms_coef_update;

   localparam int TAPS = 4;
   localparam int W    = 11;
   localparam int MU   = 8;
   localparam int FCT  = 15;
   localparam int HI   = (1 << (W - 1)) - 1;
   localparam int LO   = -(1 << (W - 1));

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                start = 1'b0;
   logic                fc = 1'b0;
   logic signed [W-1:0] err = '0;
   logic signed [W-1:0] rf = '0;
   logic signed [W-1:0] wzout = '0;
   logic                filter_en, upd_valid, busy, done, ovf, perr;
   logic signed [W-1:0] wzin;

   int checks = 0;
   int errors = 0;

   // reference model state
   int xm [TAPS];
   int em;
   bit m_ovf;
   bit m_perr;
   int wmem [TAPS];
   int got_w [TAPS];

   always #5 clk = ~clk;

   anc_lms_coef_update #(
      .TAPS(TAPS), .W(W), .MU_SHIFT(MU), .FC_TIMEOUT(FCT)
   ) dut (
      .Clk_100M(clk), .Reset(rst), .Start(start), .ErrIn(err), .RefIn(rf),
      .WzOut(wzout), .FiltComplete(fc), .FilterEN(filter_en), .WzIn(wzin),
      .UpdValid(upd_valid), .Busy(busy), .Done(done), .Overflow(ovf),
      .ProtoErr(perr)
   );

   task automatic check(input string tag, input logic signed [31:0] obs,
                        input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int rnd();
      return int'($urandom_range(2 ** W - 1, 0)) - 2 ** (W - 1);
   endfunction

   // w + floor(e*x / 2^MU), clamped to the W-bit signed range
   task automatic model_tap(input int w, input int e, input int x,
                            output int r, output bit clamp);
      longint p, den, d, s;
      p   = longint'(e) * longint'(x);
      den = longint'(1) << MU;
      if (p >= 0) d = p / den;
      else        d = -((-p + den - 1) / den);
      s     = longint'(w) + d;
      clamp = 1'b0;
      if (s > HI) begin clamp = 1'b1; s = HI; end
      if (s < LO) begin clamp = 1'b1; s = LO; end
      r = int'(s);
   endtask

   task automatic clear_model();
      for (int k = 0; k < TAPS; k++) xm[k] = 0;
      em     = 0;
      m_ovf  = 1'b0;
      m_perr = 1'b0;
   endtask

   // Entered and left just after a negedge with the DUT idle.
   task automatic run_pass(input int ev, input int rv, input bit mid_start,
                           input int fc_delay, input int abort_k,
                           input bit start_fc, input int reset_k);
      int exp_w [TAPS];
      bit cl [TAPS];
      for (int k = 0; k < TAPS; k++) got_w[k] = 9999;
      start = 1'b1;
      err   = ev[W-1:0];
      rf    = rv[W-1:0];
      fc    = start_fc;
      for (int k = TAPS - 1; k > 0; k--) xm[k] = xm[k-1];
      xm[0] = rv;
      em    = ev;
      if (start_fc) m_perr = 1'b1;
      for (int k = 0; k < TAPS; k++) model_tap(wmem[k], em, xm[k], exp_w[k], cl[k]);
      @(negedge clk);
      start = 1'b0;
      fc    = 1'b0;
      begin
         int a, b;
         a = rnd(); b = rnd();
         err = a[W-1:0];
         rf  = b[W-1:0];
      end
      check("fen_t1", filter_en, 1);
      check("upd_t1", upd_valid, 0);
      check("busy_t1", busy, 1);
      for (int c = 1; c <= TAPS + 1; c++) begin
         @(negedge clk);
         check("fen", filter_en, (c <= TAPS) ? 1 : 0);
         check("upd", upd_valid, (c >= 2) ? 1 : 0);
         check("busy", busy, 1);
         if (c >= 2) begin
            check($sformatf("wzin[%0d]", c - 2), wzin, exp_w[c-2]);
            got_w[c-2] = int'(wzin);
            if (cl[c-2]) m_ovf = 1'b1;
         end
         if (c <= TAPS) wzout = wmem[c-1][W-1:0];
         else begin
            int r;
            r = rnd();
            wzout = r[W-1:0];
         end
         if (mid_start) begin
            if (c == 2) begin
               int a, b;
               a = rnd(); b = rnd();
               start = 1'b1;
               err = a[W-1:0];
               rf  = b[W-1:0];
            end else begin
               start = 1'b0;
            end
         end
         if (reset_k >= 0 && c == reset_k + 1) begin
            #2 rst = 1'b1;
            #1;
            check("rst_fen", filter_en, 0);
            check("rst_upd", upd_valid, 0);
            check("rst_busy", busy, 0);
            check("rst_wzin", wzin, 0);
            check("rst_ovf", ovf, 0);
            check("rst_perr", perr, 0);
            clear_model();
            start = 1'b0;
            @(negedge clk);
            @(negedge clk);
            rst = 1'b0;
            return;
         end
         if (abort_k >= 0 && c == abort_k + 1) begin
            fc     = 1'b1;
            m_perr = 1'b1;
            @(negedge clk);
            fc = 1'b0;
            check("abort_fen", filter_en, 0);
            check("abort_upd", upd_valid, 0);
            check("abort_busy", busy, 0);
            check("abort_perr", perr, 1);
            check("abort_done", done, 0);
            return;
         end
      end
      start = 1'b0;
      if (fc_delay < 0) begin
         for (int i = 1; i < FCT; i++) begin
            @(negedge clk);
            check("to_busy", busy, 1);
            check("to_perr", perr, m_perr);
            check("to_done", done, 0);
         end
         @(negedge clk);
         m_perr = 1'b1;
         check("to_end_busy", busy, 0);
         check("to_end_perr", perr, 1);
         check("to_end_done", done, 0);
      end else begin
         repeat (fc_delay) begin
            @(negedge clk);
            check("wait_upd", upd_valid, 0);
            check("wait_done", done, 0);
            check("wait_busy", busy, 1);
         end
         fc = 1'b1;
         @(negedge clk);
         fc = 1'b0;
         check("done_hi", done, 1);
         check("done_busy", busy, 1);
         @(negedge clk);
         check("done_lo", done, 0);
         check("idle_busy", busy, 0);
      end
      check("ovf", ovf, m_ovf);
      check("perr", perr, m_perr);
   endtask

   initial begin
      clear_model();
      for (int k = 0; k < TAPS; k++) wmem[k] = 0;
      // reset held for 300 ns
      #100;
      check("rst_fen0", filter_en, 0);
      check("rst_upd0", upd_valid, 0);
      check("rst_busy0", busy, 0);
      check("rst_done0", done, 0);
      check("rst_ovf0", ovf, 0);
      check("rst_perr0", perr, 0);
      check("rst_wzin0", wzin, 0);
      #200;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_busy", busy, 0);
      check("post_rst_upd", upd_valid, 0);

      // e=0: coefficients pass through unchanged
      wmem = '{10, 20, -30, 5};
      run_pass(0, 7, 1'b0, 2, -1, 1'b0, -1);
      check("e0_w0", got_w[0], 10);
      check("e0_w1", got_w[1], 20);
      check("e0_w2", got_w[2], -30);
      check("e0_w3", got_w[3], 5);
      check("e0_ovf", ovf, 0);

      // four passes fill the line with 100; step = 10000>>>8 = 39
      wmem = '{10, 10, 10, 10};
      for (int p = 0; p < 4; p++) run_pass(100, 100, 1'b0, 1, -1, 1'b0, -1);
      for (int k = 0; k < TAPS; k++) check($sformatf("fill_w%0d", k), got_w[k], 49);

      // floor of a negative product
      wmem = '{0, 0, 0, 0};
      run_pass(-1, 1, 1'b0, 0, -1, 1'b0, -1);
      check("floor_w0", got_w[0], -1);

      // positive and negative saturation
      wmem = '{1000, 1000, 1000, 1000};
      run_pass(1023, 1023, 1'b0, 3, -1, 1'b0, -1);
      check("satp_w0", got_w[0], 1023);
      check("satp_ovf", ovf, 1);
      wmem = '{-1000, -1000, -1000, -1000};
      run_pass(1023, -1023, 1'b0, 0, -1, 1'b0, -1);
      check("satn_w0", got_w[0], -1024);

      // Start during STREAM is ignored; next pass shows an unshifted line
      wmem = '{3, -3, 7, -7};
      run_pass(57, -200, 1'b1, 1, -1, 1'b0, -1);
      run_pass(-300, 450, 1'b0, 2, -1, 1'b0, -1);

      // FiltComplete never arrives
      run_pass(12, 34, 1'b0, -1, -1, 1'b0, -1);

      // reset during tap 2, then a full pass from a zeroed line
      run_pass(500, 600, 1'b0, 0, -1, 1'b0, 2);
      wmem = '{1, 2, 3, 4};
      run_pass(800, 700, 1'b0, 1, -1, 1'b0, -1);
      check("zline_w1", got_w[1], 2);
      check("zline_w3", got_w[3], 4);

      // early FiltComplete aborts the pass
      run_pass(-77, 99, 1'b0, 0, 1, 1'b0, -1);
      // Start with FiltComplete in the same idle cycle
      run_pass(44, -55, 1'b0, 2, -1, 1'b1, -1);

      // randomized passes
      for (int n = 0; n < 20; n++) begin
         for (int k = 0; k < TAPS; k++) wmem[k] = rnd();
         run_pass(rnd(), rnd(), ($urandom_range(3, 0) == 0), int'($urandom_range(6, 0)),
                  -1, 1'b0, -1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/anc_lms_coef_update.md
Name: anc_lms_coef_update

Overview:
- LMS coefficient writer paired with the ANC coefficient memory.
- On each new error/reference sample pair, opens a filter pass on the memory (FilterEN) and reads every stored tap on WzOut.
- For each tap, computes w[k] + mu*e*x[k] with saturation and returns the result on WzIn for write-back.
- Closes the pass when the memory reports FiltComplete; sits between the error-microphone front end and the coefficient memory.

Parameters:
TAPS, 32, number of filter taps (coefficients per pass), 2..256
W, 11, signed width of coefficients, reference and error samples
MU_SHIFT, 8, step size mu = 2^-MU_SHIFT, 0..2*W-1
FC_TIMEOUT, 15, cycles to wait for FiltComplete after the last tap

Ports:
Clk_100M  in  1  system clock, all logic rising-edge
Reset  in  1  asynchronous, active-high reset
Start  in  1  one-cycle pulse: ErrIn/RefIn valid, begin update
ErrIn  in  W  signed error sample e
RefIn  in  W  signed reference sample, pushed into the tap delay line
WzOut  in  W  signed coefficient read from memory
FiltComplete  in  1  memory end-of-pass pulse
FilterEN  out  1  pass enable to memory
WzIn  out  W  signed updated coefficient to memory
UpdValid  out  1  WzIn valid this cycle
Busy  out  1  high whenever state != IDLE
Done  out  1  one-cycle pulse, pass finished cleanly
Overflow  out  1  sticky: any saturation since reset
ProtoErr  out  1  sticky: FiltComplete early or timed out

Behaviour:
- Reset (async, any state): state=IDLE. FilterEN, UpdValid, Busy, Done, Overflow and ProtoErr are 0. WzIn is 0. Delay line x[0..TAPS-1], error latch and tap counter are 0.
- States: IDLE, STREAM, WAIT_FC, DONE.
- IDLE: on Start=1 at cycle t0:
  - x shifts (x[k]<=x[k-1]); x[0]<=RefIn.
  - e<=ErrIn.
  - tap counter k<=0.
  - go STREAM; FilterEN=1 from t0+1.
- Memory contract: with FilterEN=1 from t1=t0+1, WzOut carries tap k at cycle t1+1+k, for k=0..TAPS-1.
- STREAM:
  - Sample WzOut at cycle t1+1+k.
  - Register the result: WzIn/UpdValid=1 at cycle t1+2+k.
  - FilterEN stays 1 through cycle t1+TAPS (last sample cycle), then drops to 0.
  - After the final WzIn is issued, go WAIT_FC.
  - UpdValid is high exactly TAPS consecutive cycles per pass.
- Arithmetic, per tap:
  - p = e*x[k], 2W-bit signed.
  - d = p >>> MU_SHIFT (arithmetic shift; floors toward -inf).
  - s = WzOut + d, computed at 2W+1 bits.
  - WzIn = sat(s) into [-2^(W-1), 2^(W-1)-1].
  - On clamp, set Overflow=1 (sticky until Reset).
- WAIT_FC:
  - FiltComplete=1 -> go DONE.
  - No FiltComplete within FC_TIMEOUT cycles -> ProtoErr=1, go IDLE, no Done.
- FiltComplete=1 in any state other than WAIT_FC: set ProtoErr=1. In STREAM, also abort: FilterEN=0, UpdValid=0, go IDLE, no Done. Coefficients already written are not rolled back.
- DONE: Done=1 for one cycle, then IDLE. Start is accepted again from the cycle after Done.
- Start while Busy=1 is ignored: no delay-line shift, no error latch change.
- Start and FiltComplete in the same IDLE cycle: ProtoErr=1 and the Start is accepted.
- ErrIn and RefIn changes after t0 have no effect on the current pass.

Test Plan:
- Reset = 1 for 300 ns, then release. Required: every output 0, Busy=0, no UpdValid.
- TAPS=4, e=0, memory returns {10,20,-30,5}. Required: WzIn={10,20,-30,5}, UpdValid for 4 cycles, then Done pulse; Overflow=0.
- e=100, four Starts with RefIn=100, WzOut=10 on all taps. Required: on the 4th pass every tap has x=100, d=10000>>>8=39, so WzIn=49 on all taps.
- e=-1, x[0]=1, WzOut=0. Required: d=-1, WzIn[0]=-1 (floor behaviour). Also: WzOut=1000, e=x=1023, MU_SHIFT=8. Required: WzIn=1023 and Overflow=1; the mirrored negative case clamps to -1024.
- Start pulsed again mid-STREAM. Required: ignored, x unchanged. FiltComplete held low after the last tap. Required: ProtoErr=1 after 15 cycles, no Done, return to IDLE.
- Reset asserted mid-STREAM (tap 2 of 4). Required: FilterEN and UpdValid drop immediately (asynchronously); the next Start runs a full 4-tap pass with a zeroed delay line.
